// File: rtl/ioctl_pkg.sv
// Shared constants for the HPS ioctl download receiver: stream indices,
// packer state encoding and memory byte-enable codes.
package ioctl_pkg;

   localparam logic [15:0] IDX_ROM   = 16'd0;
   localparam logic [15:0] IDX_DIPSW = 16'd254;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HOLD  = 2'd1,
      S_ISSUE = 2'd2,
      S_FLUSH = 2'd3
   } ld_state_t;

   localparam logic [1:0] BE_LO   = 2'b01;
   localparam logic [1:0] BE_HI   = 2'b10;
   localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/ioctl_rom_loader_if.sv
// HPS ioctl byte stream plus the shared ROM/SDRAM write port.
// master = HPS and memory side, slave = the loader core.
interface ioctl_rom_loader_if #(
   parameter int MEM_AW = 20
);
   logic              ioctl_download;
   logic [15:0]       ioctl_index;
   logic [26:0]       ioctl_addr;
   logic [7:0]        ioctl_data;
   logic              ioctl_wr;
   logic              ioctl_wait;
   logic              mem_req;
   logic [MEM_AW-1:0] mem_addr;
   logic [15:0]       mem_data;
   logic [1:0]        mem_be;
   logic              mem_ack;

   modport master (
      output ioctl_download, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr, mem_ack,
      input  ioctl_wait, mem_req, mem_addr, mem_data, mem_be
   );

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr, mem_ack,
      output ioctl_wait, mem_req, mem_addr, mem_data, mem_be
   );
endinterface

// File: rtl/ioctl_byte_packer.sv
// Pairs ROM bytes into 16-bit words, holds one overflow byte in a skid
// register, and runs the req/ack handshake toward the memory port.
//
//   state   | meaning
//   IDLE    | nothing pending; a buffered skid byte is consumed here first
//   HOLD    | even byte latched, waiting for its odd partner
//   ISSUE   | word/byte request outstanding until mem_ack
//   FLUSH   | final lone low byte outstanding at end of download
module ioctl_byte_packer
   import ioctl_pkg::*;
#(
   parameter int MEM_AW = 20
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              restart,
   input  logic              byte_valid,
   input  logic [MEM_AW:0]   byte_addr,
   input  logic [7:0]        byte_data,
   input  logic              finish,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [15:0]       mem_data,
   output logic [1:0]        mem_be,
   output logic              stall,
   output logic              done
);
   ld_state_t         state, state_n;
   logic [MEM_AW-1:0] hold_addr, hold_addr_n;
   logic [7:0]        hold_data, hold_data_n;
   logic              skid_valid, skid_valid_n;
   logic [MEM_AW:0]   skid_addr, skid_addr_n;
   logic [7:0]        skid_data, skid_data_n;
   logic              fin_pend, fin_pend_n;
   logic [MEM_AW-1:0] addr_n;
   logic [15:0]       data_n;
   logic [1:0]        be_n;
   logic              req_n;
   logic              in_valid;
   logic [MEM_AW:0]   in_addr;
   logic [7:0]        in_data;

   // The skid byte takes priority; stall keeps the HPS from strobing meanwhile.
   assign in_valid = skid_valid | byte_valid;
   assign in_addr  = skid_valid ? skid_addr : byte_addr;
   assign in_data  = skid_valid ? skid_data : byte_data;

   always_comb begin
      state_n      = state;
      hold_addr_n  = hold_addr;
      hold_data_n  = hold_data;
      skid_valid_n = skid_valid;
      skid_addr_n  = skid_addr;
      skid_data_n  = skid_data;
      fin_pend_n   = fin_pend | finish;
      addr_n       = mem_addr;
      data_n       = mem_data;
      be_n         = mem_be;
      done         = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (in_valid) begin
               skid_valid_n = 1'b0;
               if (!in_addr[0]) begin
                  state_n     = S_HOLD;
                  hold_addr_n = in_addr[MEM_AW:1];
                  hold_data_n = in_data;
               end else begin
                  state_n = S_ISSUE;
                  addr_n  = in_addr[MEM_AW:1];
                  data_n  = {in_data, 8'h00};
                  be_n    = BE_HI;
               end
            end else if (fin_pend_n) begin
               done       = 1'b1;
               fin_pend_n = 1'b0;
            end
         end
         S_HOLD: begin
            if (byte_valid) begin
               state_n = S_ISSUE;
               addr_n  = hold_addr;
               if (byte_addr[0] && byte_addr[MEM_AW:1] == hold_addr) begin
                  data_n = {byte_data, hold_data};
                  be_n   = BE_WORD;
               end else begin
                  data_n       = {8'h00, hold_data};
                  be_n         = BE_LO;
                  skid_valid_n = 1'b1;
                  skid_addr_n  = byte_addr;
                  skid_data_n  = byte_data;
               end
            end else if (fin_pend_n) begin
               state_n = S_FLUSH;
               addr_n  = hold_addr;
               data_n  = {8'h00, hold_data};
               be_n    = BE_LO;
            end
         end
         S_ISSUE: begin
            if (mem_ack) begin
               if (skid_valid && !skid_addr[0]) begin
                  state_n      = S_HOLD;
                  hold_addr_n  = skid_addr[MEM_AW:1];
                  hold_data_n  = skid_data;
                  skid_valid_n = 1'b0;
               end else begin
                  state_n = S_IDLE;
               end
            end
         end
         S_FLUSH: begin
            if (mem_ack) begin
               state_n    = S_IDLE;
               done       = 1'b1;
               fin_pend_n = 1'b0;
            end
         end
         default: state_n = S_IDLE;
      endcase
      req_n = (state_n == S_ISSUE) || (state_n == S_FLUSH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         hold_addr  <= '0;
         hold_data  <= '0;
         skid_valid <= 1'b0;
         skid_addr  <= '0;
         skid_data  <= '0;
         fin_pend   <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         mem_be     <= '0;
         stall      <= 1'b0;
      end else if (restart) begin
         state      <= S_IDLE;
         skid_valid <= 1'b0;
         fin_pend   <= 1'b0;
         mem_req    <= 1'b0;
         stall      <= 1'b0;
      end else begin
         state      <= state_n;
         hold_addr  <= hold_addr_n;
         hold_data  <= hold_data_n;
         skid_valid <= skid_valid_n;
         skid_addr  <= skid_addr_n;
         skid_data  <= skid_data_n;
         fin_pend   <= fin_pend_n;
         mem_req    <= req_n;
         mem_addr   <= addr_n;
         mem_data   <= data_n;
         mem_be     <= be_n;
         stall      <= req_n | skid_valid_n;
      end
   end
endmodule

// File: rtl/ioctl_rom_loader.sv
// Core-side ioctl receiver: ROM image into memory via the byte packer,
// DIP switch bytes into a register bank, core reset held until ROM loaded.
module ioctl_rom_loader
   import ioctl_pkg::*;
#(
   parameter logic [26:0]              ROM_SIZE      = 27'h010_0000,
   parameter int                       MEM_AW        = 20,
   parameter int                       DIPSW_BYTES   = 3,
   parameter logic [8*DIPSW_BYTES-1:0] DIPSW_DEFAULT = 24'hFFFFFF
)(
   input  logic                     hpsio_clk,
   input  logic                     rst,
   ioctl_rom_loader_if.slave        bus,
   output logic [8*DIPSW_BYTES-1:0] dipsw,
   output logic                     rom_loaded,
   output logic                     cpu_rst,
   output logic                     err_oor
);
   logic wr_q, dl_q;
   logic stb, dl_start, dl_end;
   logic rom_idx, dip_idx, rom_stb, dip_stb;
   logic blocked, rom_oor, rom_byte, dip_wr;
   logic rom_active, restart, finish, stall, done;

   assign stb      = bus.ioctl_wr & ~wr_q;
   assign dl_start = bus.ioctl_download & ~dl_q;
   assign dl_end   = ~bus.ioctl_download & dl_q;
   assign rom_idx  = (bus.ioctl_index == IDX_ROM);
   assign dip_idx  = (bus.ioctl_index == IDX_DIPSW);
   assign rom_stb  = stb & bus.ioctl_download & rom_idx;
   assign dip_stb  = stb & bus.ioctl_download & dip_idx;
   // A strobe during WAIT breaks the HPS protocol: drop it and flag it.
   assign blocked  = (rom_stb | dip_stb) & stall;
   assign rom_oor  = rom_stb & ~stall & (bus.ioctl_addr >= ROM_SIZE);
   assign rom_byte = rom_stb & ~stall & (bus.ioctl_addr < ROM_SIZE);
   assign dip_wr   = dip_stb & ~stall & (bus.ioctl_addr < 27'(DIPSW_BYTES));
   assign restart  = dl_start & rom_idx;
   assign finish   = dl_end & rom_active;
   assign bus.ioctl_wait = stall;

   ioctl_byte_packer #(.MEM_AW(MEM_AW)) u_packer (
      .clk        (hpsio_clk),
      .rst        (rst),
      .restart    (restart),
      .byte_valid (rom_byte),
      .byte_addr  (bus.ioctl_addr[MEM_AW:0]),
      .byte_data  (bus.ioctl_data),
      .finish     (finish),
      .mem_ack    (bus.mem_ack),
      .mem_req    (bus.mem_req),
      .mem_addr   (bus.mem_addr),
      .mem_data   (bus.mem_data),
      .mem_be     (bus.mem_be),
      .stall      (stall),
      .done       (done)
   );

   always_ff @(posedge hpsio_clk) begin
      if (rst) begin
         wr_q       <= 1'b0;
         dl_q       <= 1'b0;
         rom_active <= 1'b0;
         rom_loaded <= 1'b0;
         cpu_rst    <= 1'b1;
         err_oor    <= 1'b0;
         dipsw      <= DIPSW_DEFAULT;
      end else begin
         wr_q <= bus.ioctl_wr;
         dl_q <= bus.ioctl_download;
         if (restart) begin
            rom_active <= 1'b1;
            rom_loaded <= 1'b0;
            cpu_rst    <= 1'b1;
            err_oor    <= 1'b0;
         end else if (dl_end) begin
            rom_active <= 1'b0;
         end
         if (done) begin
            rom_loaded <= 1'b1;
            cpu_rst    <= 1'b0;
         end
         if (rom_oor | blocked) err_oor <= 1'b1;
         for (int n = 0; n < DIPSW_BYTES; n++) begin
            if (dip_wr && bus.ioctl_addr == 27'(n)) dipsw[8*n +: 8] <= bus.ioctl_data;
         end
      end
   end
endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Directed and randomized downloads checked against a list-based model of
// the expected memory writes and DIP bank contents.
module tb_ioctl_rom_loader;
   import ioctl_pkg::*;

   localparam int          MEM_AW   = 20;
   localparam logic [26:0] ROM_SIZE = 27'h010_0000;

   typedef struct packed {
      logic [MEM_AW-1:0] a;
      logic [15:0]       d;
      logic [1:0]        be;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] dipsw;
   logic        rom_loaded, cpu_rst, err_oor;

   ioctl_rom_loader_if #(.MEM_AW(MEM_AW)) bus ();

   ioctl_rom_loader #(
      .ROM_SIZE      (ROM_SIZE),
      .MEM_AW        (MEM_AW),
      .DIPSW_BYTES   (3),
      .DIPSW_DEFAULT (24'hFFFFFF)
   ) dut (
      .hpsio_clk  (clk),
      .rst        (rst),
      .bus        (bus),
      .dipsw      (dipsw),
      .rom_loaded (rom_loaded),
      .cpu_rst    (cpu_rst),
      .err_oor    (err_oor)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   wr_t         got[$];
   wr_t         exp_q[$];
   logic        exp_err;
   logic [26:0] q_addr[$];
   logic [7:0]  q_data[$];

   // memory responder
   int ack_delay  = 2;
   int ack_cnt    = 0;
   bit ack_en     = 1'b1;
   bit rand_delay = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         bus.mem_ack = 1'b0;
         ack_cnt     = 0;
      end else if (bus.mem_ack) begin
         bus.mem_ack = 1'b0;
      end else if (bus.mem_req && ack_en) begin
         if (ack_cnt >= ack_delay) begin
            bus.mem_ack = 1'b1;
            got.push_back(wr_t'{bus.mem_addr, bus.mem_data, bus.mem_be});
            ack_cnt = 0;
            if (rand_delay) ack_delay = $urandom_range(0, 3);
         end else begin
            ack_cnt++;
         end
      end else begin
         ack_cnt = 0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mask(input logic [15:0] d, input logic [1:0] be);
      return d & {{8{be[1]}}, {8{be[0]}}};
   endfunction

   // Expected writes: even byte waits for its odd partner of the same word,
   // anything else forces the waiting byte out alone; a leftover goes out at the end.
   task automatic build_model();
      logic              pv;
      logic [MEM_AW-1:0] pw, w;
      logic [7:0]        pd, d;
      logic [26:0]       a;
      pv = 1'b0; pw = '0; pd = '0;
      exp_q.delete();
      exp_err = 1'b0;
      for (int i = 0; i < q_addr.size(); i++) begin
         a = q_addr[i];
         d = q_data[i];
         w = a[MEM_AW:1];
         if (a >= ROM_SIZE) begin
            exp_err = 1'b1;
         end else if (pv && a[0] && w == pw) begin
            exp_q.push_back(wr_t'{pw, {d, pd}, 2'b11});
            pv = 1'b0;
         end else begin
            if (pv) begin
               exp_q.push_back(wr_t'{pw, {8'h00, pd}, 2'b01});
               pv = 1'b0;
            end
            if (!a[0]) begin
               pv = 1'b1; pw = w; pd = d;
            end else begin
               exp_q.push_back(wr_t'{w, {d, 8'h00}, 2'b10});
            end
         end
      end
      if (pv) exp_q.push_back(wr_t'{pw, {8'h00, pd}, 2'b01});
   endtask

   task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
      int n = 0;
      while (bus.ioctl_wait !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("wait_timeout", 64'(bus.ioctl_wait), 64'd0);
      bus.ioctl_addr = a;
      bus.ioctl_data = d;
      bus.ioctl_wr   = 1'b1;
      repeat ($urandom_range(1, 2)) @(negedge clk);
      bus.ioctl_wr = 1'b0;
      @(negedge clk);
   endtask

   task automatic add_byte(input logic [26:0] a, input logic [7:0] d);
      q_addr.push_back(a);
      q_data.push_back(d);
   endtask

   task automatic start_dl(input logic [15:0] idx);
      got.delete();
      q_addr.delete();
      q_data.delete();
      bus.ioctl_index    = idx;
      bus.ioctl_download = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_all();
      for (int i = 0; i < q_addr.size(); i++) send_byte(q_addr[i], q_data[i]);
   endtask

   task automatic wait_quiet(input string tag);
      int n = 0;
      while ((bus.mem_req !== 1'b0 || bus.ioctl_wait !== 1'b0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_quiet"}, 64'({bus.mem_req, bus.ioctl_wait}), 64'd0);
   endtask

   task automatic end_rom(input string tag);
      int n = 0;
      bus.ioctl_download = 1'b0;
      while (rom_loaded !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      build_model();
      check({tag, "_loaded"}, 64'(rom_loaded), 64'd1);
      check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd0);
      check({tag, "_nreq"}, 64'(got.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), 64'(got[i].a), 64'(exp_q[i].a));
         check($sformatf("%s_be%0d", tag, i), 64'(got[i].be), 64'(exp_q[i].be));
         check($sformatf("%s_data%0d", tag, i), 64'(mask(got[i].d, got[i].be)),
               64'(mask(exp_q[i].d, exp_q[i].be)));
      end
      check({tag, "_err"}, 64'(err_oor), 64'(exp_err));
   endtask

   initial begin
      logic [26:0] a;
      int          nb;
      bus.ioctl_download = 1'b0;
      bus.ioctl_index    = 16'd0;
      bus.ioctl_addr     = '0;
      bus.ioctl_data     = '0;
      bus.ioctl_wr       = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_req", 64'(bus.mem_req), 64'd0);
      check("rst_wait", 64'(bus.ioctl_wait), 64'd0);
      check("rst_loaded", 64'(rom_loaded), 64'd0);
      check("rst_err", 64'(err_oor), 64'd0);
      check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
      check("rst_dipsw", 64'(dipsw), 64'hFFFFFF);
      check("rst_mem", 64'({bus.mem_addr, bus.mem_data, bus.mem_be}), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // sequential four-byte image
      start_dl(IDX_ROM);
      check("a_loaded_start", 64'(rom_loaded), 64'd0);
      add_byte(27'd0, 8'h11); add_byte(27'd1, 8'h22);
      add_byte(27'd2, 8'h33); add_byte(27'd3, 8'h44);
      send_all();
      wait_quiet("a");
      bus.ioctl_download = 1'b0;
      @(negedge clk);
      check("a_loaded_1cyc", 64'(rom_loaded), 64'd1);
      check("a_cpu_rst_1cyc", 64'(cpu_rst), 64'd0);
      end_rom("a");

      // odd length: last byte goes out through FLUSH
      start_dl(IDX_ROM);
      check("b_loaded_cleared", 64'(rom_loaded), 64'd0);
      check("b_cpu_rst_set", 64'(cpu_rst), 64'd1);
      add_byte(27'd0, 8'hAA); add_byte(27'd1, 8'hBB); add_byte(27'd2, 8'hCC);
      send_all();
      wait_quiet("b");
      bus.ioctl_download = 1'b0;
      @(negedge clk);
      check("b_loaded_early", 64'(rom_loaded), 64'd0);
      check("b_flush_req", 64'(bus.mem_req), 64'd1);
      end_rom("b");

      // non-sequential evens exercise the skid register
      start_dl(IDX_ROM);
      add_byte(27'd4, 8'h5A); add_byte(27'd8, 8'hA5);
      send_byte(27'd4, 8'h5A);
      send_byte(27'd8, 8'hA5);
      check("c_skid_wait", 64'(bus.ioctl_wait), 64'd1);
      wait_quiet("c");
      end_rom("c");

      // out-of-range byte is dropped and flagged
      start_dl(IDX_ROM);
      add_byte(ROM_SIZE, 8'h55);
      send_all();
      wait_quiet("d");
      end_rom("d");
      start_dl(IDX_ROM);
      check("d_err_cleared", 64'(err_oor), 64'd0);
      end_rom("d2");

      // DIP bank
      start_dl(IDX_DIPSW);
      send_byte(27'd0, 8'hFE); check("e_wait0", 64'(bus.ioctl_wait), 64'd0);
      send_byte(27'd1, 8'h7F); check("e_wait1", 64'(bus.ioctl_wait), 64'd0);
      send_byte(27'd2, 8'h01); check("e_wait2", 64'(bus.ioctl_wait), 64'd0);
      send_byte(27'd3, 8'hFF); check("e_wait3", 64'(bus.ioctl_wait), 64'd0);
      bus.ioctl_download = 1'b0;
      @(negedge clk);
      check("e_dipsw", 64'(dipsw), 64'h017FFE);
      check("e_no_req", 64'(got.size()), 64'd0);

      // randomized images, random ack latency, download may end mid-request
      rand_delay = 1'b1;
      for (int it = 0; it < 4; it++) begin
         start_dl(IDX_ROM);
         a  = 27'($urandom_range(0, 15));
         nb = $urandom_range(5, 14);
         for (int k = 0; k < nb; k++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4, 5: a = a + 27'd1;
               6, 7, 8:          a = 27'($urandom_range(0, 255));
               default:          add_byte(ROM_SIZE + 27'($urandom_range(0, 3)), 8'($urandom));
            endcase
            add_byte(a, 8'($urandom));
         end
         send_all();
         end_rom($sformatf("r%0d", it));
      end
      rand_delay = 1'b0;
      ack_delay  = 2;

      // reset while a request is outstanding
      start_dl(IDX_ROM);
      ack_en = 1'b0;
      send_byte(27'd0, 8'h12);
      send_byte(27'd1, 8'h34);
      check("g_req_held", 64'(bus.mem_req), 64'd1);
      rst = 1'b1;
      bus.ioctl_download = 1'b0;
      @(negedge clk);
      check("g_req_drop", 64'(bus.mem_req), 64'd0);
      check("g_cpu_rst", 64'(cpu_rst), 64'd1);
      check("g_dipsw", 64'(dipsw), 64'hFFFFFF);
      rst    = 1'b0;
      ack_en = 1'b1;
      @(negedge clk);
      start_dl(IDX_ROM);
      add_byte(27'd0, 8'h9C); add_byte(27'd1, 8'h3E); add_byte(27'd2, 8'h71);
      send_all();
      end_rom("g");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ioctl_rom_loader.md
Name: ioctl_rom_loader

Overview:
- Core-side receiver for the HPS ioctl download stream.
- Index 0 (ROM image): packs bytes into 16-bit words and sequences them into the shared ROM/SDRAM write port with a req/ack handshake, throttling the HPS through o_IOCTL_WAIT.
- Index 254 (DIP switches): latches bytes into the DIP switch register bank.
- Holds the game core in reset until the ROM image is complete.

Parameters:
- ROM_SIZE, 27'h010_0000, ROM image byte count. Bytes at or above this address are dropped.
- MEM_AW, 20, word-address width of the memory port (byte address bits [MEM_AW:1]).
- DIPSW_BYTES, 3, number of DIP switch bytes kept.
- DIPSW_DEFAULT, 24'hFFFFFF, DIP bank value after reset.

Ports:
- i_HPSIO_CLK  in  1  sole clock; all logic on rising edge
- i_RST  in  1  synchronous, active-high reset
- i_IOCTL_DOWNLOAD  in  1  download window active
- i_IOCTL_INDEX  in  16  stream type (0 = ROM, 254 = DIP)
- i_IOCTL_ADDR  in  27  byte address within the stream
- i_IOCTL_DATA  in  8  byte data
- i_IOCTL_WR  in  1  byte strobe
- o_IOCTL_WAIT  out  1  back-pressure to HPS
- o_MEM_REQ  out  1  write request, held until ack
- o_MEM_ADDR  out  MEM_AW  word address
- o_MEM_DATA  out  16  write data; low byte = even address
- o_MEM_BE  out  2  byte enables ([0] = low byte)
- i_MEM_ACK  in  1  one-cycle acknowledge
- o_DIPSW  out  8*DIPSW_BYTES  DIP bank; byte n at bits [8n+7:8n]
- o_ROM_LOADED  out  1  ROM image complete
- o_CPU_RST  out  1  core reset request
- o_ERR_OOR  out  1  sticky: ROM byte dropped as out of range

Behaviour:
- Reset values:
  - REQ, WAIT, ROM_LOADED, ERR_OOR = 0; MEM_ADDR/DATA/BE = 0.
  - o_CPU_RST = 1; o_DIPSW = DIPSW_DEFAULT.
  - FSM = IDLE; pending-byte flag = 0.
- Strobe: stb = i_IOCTL_WR & ~wr_q (rising-edge detect, wr_q registered). Each strobe is exactly one byte; multi-cycle WR is accepted.
- Bytes arriving with i_IOCTL_DOWNLOAD = 0, or with an index other than 0 or 254, are ignored.
- dl_start / dl_end = rising / falling edge of i_IOCTL_DOWNLOAD.
- On dl_start with index 0:
  - ROM_LOADED <= 0, ERR_OOR <= 0, CPU_RST <= 1.
  - Pending flag cleared.
- DIP stream (index 254):
  - stb with addr < DIPSW_BYTES: write o_DIPSW byte[addr] the next cycle.
  - Other addresses ignored.
  - WAIT is never raised for DIP bytes.
- ROM stream (index 0), FSM states IDLE, HOLD, ISSUE, FLUSH:
  - addr >= ROM_SIZE: byte dropped, ERR_OOR <= 1, no state change.
  - IDLE, even addr: latch low byte and word address, go to HOLD.
  - IDLE, odd addr: go to ISSUE with BE = 2'b10 (data in [15:8]).
  - HOLD, odd addr with the same word address: merge, ISSUE with BE = 2'b11.
  - HOLD, any other in-range addr: ISSUE the pending byte with BE = 2'b01, keep the new byte in a 1-deep skid register, then process it as from IDLE after the ack.
  - ISSUE: REQ = 1 with ADDR/DATA/BE stable until the i_MEM_ACK cycle. The cycle after ack: REQ = 0; go to IDLE, or HOLD if the skid byte was even.
  - HOLD on dl_end: go to FLUSH (BE = 2'b01), same handshake as ISSUE.
  - dl_end in IDLE or after FLUSH ack: ROM_LOADED <= 1, CPU_RST <= 0 the next cycle.
  - dl_end during ISSUE: complete the ack first, then flush the skid/pending byte if any, then set ROM_LOADED.
- o_IOCTL_WAIT:
  - Registered.
  - 1 from the cycle after a strobe that enters ISSUE or FLUSH until the cycle after ack.
  - Also 1 while the skid register is occupied.
- A strobe arriving while WAIT = 1 (HPS protocol violation) is dropped and ERR_OOR is set.
- i_MEM_ACK outside ISSUE/FLUSH is ignored.
- i_RST mid-transfer: all state is abandoned and REQ falls the cycle after reset is sampled. The memory side must tolerate a withdrawn request.

Decomposition:
- Shared package ioctl_pkg:
  - IDX_ROM = 16'd0, IDX_DIPSW = 16'd254.
  - FSM state enum.
  - BE encodings (BE_LO, BE_HI, BE_WORD).
- Sub-module ioctl_byte_packer: byte-to-word pairing plus skid register, owning HOLD/ISSUE/FLUSH and the memory handshake.
- Top level: edge detects, index decode, DIP bank, CPU reset, and error flag.

Test Plan:
- Index 0: bytes 11,22,33,44 at addr 0..3, ack 2 cycles after REQ, then dl_end -> two requests: (addr 0, data 16'h2211, BE 11) and (addr 1, data 16'h4433, BE 11); ROM_LOADED=1 and CPU_RST=0 one cycle after dl_end.
- Odd-length image: 3 bytes AA,BB,CC then dl_end -> second request is addr 1, data[7:0]=CC, BE 01 (FLUSH); ROM_LOADED is set only after that ack.
- Non-sequential addresses: even addr 4 then even addr 8 -> request (word 2, BE 01); WAIT high while the skid holds addr 8; after dl_end a FLUSH (word 4, BE 01).
- Addr ROM_SIZE with data 55 -> no request, ERR_OOR=1; ERR_OOR clears on the next index-0 dl_start.
- Index 254: bytes FE,7F,01,FF at addr 0..3 -> o_DIPSW = 24'h017FFE; WAIT stays 0; addr 3 ignored.
- i_RST asserted while REQ=1 and ack withheld -> REQ=0, CPU_RST=1, o_DIPSW=24'hFFFFFF next cycle; a fresh download then completes normally.
